exec_alu_branch: RTL and testbench
==================================

Name: exec_alu_branch

Overview:
- Registered execute-stage datapath slice combining three functions:
  - the integer ALU;
  - the branch-target adder;
  - the branch/jump resolution logic that drives the PC-next select.
- Sits between the decode/execute pipeline register and the execute/memory register. The target and select feed back to the fetch-stage PC mux.
- All outputs are registered with 1-cycle latency.

Parameters:
- XLEN, 32, datapath width for operands, result and target. Only 32 is required to be supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low
- in_valid  input  1  operands and controls valid this cycle
- srcA  input  XLEN  ALU operand A (already forwarded/muxed)
- srcB  input  XLEN  ALU operand B (register or immediate)
- ALUControl  input  4  operation select
- branch  input  6  one-hot branch type: [0]BEQ [1]BNE [2]BLT [3]BGE [4]BLTU [5]BGEU
- jump  input  1  unconditional jump
- targetBase  input  XLEN  PC or rs1 value for the target adder
- targetOffset  input  XLEN  sign-extended immediate
- out_valid  output  1  registered in_valid
- ALUResult  output  XLEN  registered ALU result
- flags  output  4  registered flags: [0]Z [1]N [2]C [3]V
- PCTarget  output  XLEN  registered targetBase+targetOffset
- PCNextSrc  output  1  registered redirect: 1 = take PCTarget

Behaviour:
- Reset:
  - The reset is synchronous and active-low.
  - On a clk edge with rst=0, all outputs clear to 0: out_valid, ALUResult, flags, PCTarget, PCNextSrc.
  - Reset overrides in_valid.
  - Reset asserted mid-stream drops any in-flight result.
- Latency: inputs sampled at a rising edge appear on the outputs immediately after that edge (1 cycle).
- in_valid=1 at the edge: all outputs load the newly computed values.
- in_valid=0 at the edge:
  - out_valid and PCNextSrc load 0.
  - ALUResult, flags and PCTarget hold their previous values.
- ALUControl encodings. Results are XLEN bits and wrap modulo 2^XLEN.
  - 0000 ADD: A+B
  - 0001 SUB: A-B
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL: A << B[4:0]
  - 0110 SRL: logical right shift by B[4:0]
  - 0111 SRA: arithmetic right shift by B[4:0]
  - 1000 SLT: 1 if signed A<B, else 0
  - 1001 SLTU: 1 if unsigned A<B, else 0
  - 1010 PASSB: B
  - 1011–1111: result 0
- Flags come from the comparison subtractor D = A - B, independent of ALUControl:
  - Z = (D==0)
  - N = D[XLEN-1]
  - C = carry-out of A + ~B + 1, i.e. 1 when A ≥ B unsigned
  - V = signed overflow of the subtraction, i.e. A and B signs differ and D sign differs from A
- Branch conditions:
  - BEQ = Z
  - BNE = ~Z
  - BLT = N^V
  - BGE = ~(N^V)
  - BLTU = ~C
  - BGEU = C
- Redirect: taken = OR over each set branch bit ANDed with its condition. PCNextSrc = in_valid & (jump | taken).
  - Multiple branch bits set: their conditions are ORed (no error).
  - branch=0 with jump=0 gives no redirect.
- Target adder: PCTarget = targetBase + targetOffset, wrap modulo 2^XLEN, no overflow indication. It is computed every valid cycle regardless of branch/jump.
- No state beyond the output registers. There are no stalls or backpressure.

Test Plan:
- Reset: drive rst=0 for 2 edges with in_valid=1 and nonzero inputs → all outputs 0. Release rst=1 → first valid result appears one edge later.
- Arithmetic and wrap:
  - ADD A=0xFFFFFFFF, B=1 → ALUResult=0; Z=0 (flags reflect A-B); C=1.
  - SUB A=5, B=5 → ALUResult=0, Z=1, C=1, N=0, V=0.
- Shifts and compares:
  - SRA A=0x80000000, B=0x24 (shamt 4) → 0xF8000000.
  - SRL on the same inputs → 0x08000000.
  - SLT A=-1, B=1 → 1.
  - SLTU A=-1, B=1 → 0.
- Overflow: SUB A=0x80000000, B=1 → ALUResult=0x7FFFFFFF, V=1, N=0, BLT taken (N^V=1). BLTU not taken (C=1).
- Branch/jump:
  - branch=BNE, A=3, B=3, jump=0 → PCNextSrc=0.
  - jump=1, targetBase=0x100, targetOffset=0xFFFFFFF8 → PCNextSrc=1, PCTarget=0xF8.
- Invalid hold: a valid ADD of 2+3 (result 5), then in_valid=0 with different inputs → ALUResult stays 5, out_valid=0, PCNextSrc=0.

Source files
------------

// File: rtl/exec_alu_branch.sv
// Execute-stage slice: integer ALU, branch-target adder and branch/jump
// resolution. Every output is registered, so results appear one edge after
// the inputs are sampled.
module exec_alu_branch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,          // synchronous, active-low
  input  logic            in_valid,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [3:0]      ALUControl,
  input  logic [5:0]      branch,       // [0]BEQ [1]BNE [2]BLT [3]BGE [4]BLTU [5]BGEU
  input  logic            jump,
  input  logic [XLEN-1:0] targetBase,
  input  logic [XLEN-1:0] targetOffset,
  output logic            out_valid,
  output logic [XLEN-1:0] ALUResult,
  output logic [3:0]      flags,        // [0]Z [1]N [2]C [3]V
  output logic [XLEN-1:0] PCTarget,
  output logic            PCNextSrc
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
    OP_XOR = 4'b0100, OP_SLL = 4'b0101, OP_SRL  = 4'b0110, OP_SRA  = 4'b0111,
    OP_SLT = 4'b1000, OP_SLTU = 4'b1001, OP_PASSB = 4'b1010
  } alu_op_e;

  logic            valid_q,  valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [3:0]      flags_q,  flags_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            pcsel_q,  pcsel_d;

  // Shared comparison subtractor: A + ~B + 1, carry-out kept in the top bit.
  logic [XLEN:0]   sub_w;
  logic [XLEN-1:0] diff;
  logic            fz, fn, fc, fv;
  logic [SHW-1:0]  shamt;

  assign sub_w = {1'b0, srcA} + {1'b0, ~srcB} + {{XLEN{1'b0}}, 1'b1};
  assign diff  = sub_w[XLEN-1:0];
  assign fz    = (diff == '0);
  assign fn    = diff[XLEN-1];
  assign fc    = sub_w[XLEN];
  assign fv    = (srcA[XLEN-1] ^ srcB[XLEN-1]) & (diff[XLEN-1] ^ srcA[XLEN-1]);
  assign shamt = srcB[SHW-1:0];

  // ALU result select; undefined encodings produce zero.
  always_comb begin
    result_d = '0;
    case (alu_op_e'(ALUControl))
      OP_ADD:   result_d = srcA + srcB;
      OP_SUB:   result_d = diff;
      OP_AND:   result_d = srcA & srcB;
      OP_OR:    result_d = srcA | srcB;
      OP_XOR:   result_d = srcA ^ srcB;
      OP_SLL:   result_d = srcA << shamt;
      OP_SRL:   result_d = srcA >> shamt;
      OP_SRA:   result_d = $unsigned($signed(srcA) >>> shamt);
      OP_SLT:   result_d = {{(XLEN-1){1'b0}}, fn ^ fv};
      OP_SLTU:  result_d = {{(XLEN-1){1'b0}}, ~fc};
      OP_PASSB: result_d = srcB;
      default:  result_d = '0;
    endcase
  end

  // Branch resolution and next-state selection; invalid cycles hold the
  // datapath registers and clear the valid/redirect bits.
  always_comb begin
    logic [5:0] cond;
    logic       taken;
    cond     = {fc, ~fc, ~(fn ^ fv), fn ^ fv, ~fz, fz};
    taken    = |(branch & cond);
    valid_d  = in_valid;
    pcsel_d  = in_valid & (jump | taken);
    flags_d  = flags_q;
    target_d = target_q;
    if (in_valid) begin
      flags_d  = {fv, fc, fn, fz};
      target_d = targetBase + targetOffset;
    end
  end

  // Output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      target_q <= '0;
      pcsel_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      pcsel_q  <= pcsel_d;
      flags_q  <= flags_d;
      target_q <= target_d;
      if (in_valid) result_q <= result_d;
    end
  end

  assign out_valid = valid_q;
  assign ALUResult = result_q;
  assign flags     = flags_q;
  assign PCTarget  = target_q;
  assign PCNextSrc = pcsel_q;

endmodule

// File: tb/tb_exec_alu_branch.sv
// Bench for exec_alu_branch: directed vectors with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_exec_alu_branch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] srcA, srcB, targetBase, targetOffset;
  logic [3:0]  ALUControl;
  logic [5:0]  branch;
  logic        jump;
  logic        out_valid, PCNextSrc;
  logic [31:0] ALUResult, PCTarget;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  exec_alu_branch #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .srcA(srcA), .srcB(srcB),
    .ALUControl(ALUControl), .branch(branch), .jump(jump),
    .targetBase(targetBase), .targetOffset(targetOffset),
    .out_valid(out_valid), .ALUResult(ALUResult), .flags(flags),
    .PCTarget(PCTarget), .PCNextSrc(PCNextSrc)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic [31:0] fill;
    sh = int'(b[4:0]);
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return (a >> sh) | fill;
      4'd8:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] m_flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    longint sd;
    logic z, n, c, v;
    d  = a - b;
    sd = longint'($signed(a)) - longint'($signed(b));
    z  = (a == b);
    n  = d[31];
    c  = (a >= b);
    v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {v, c, n, z};
  endfunction

  function automatic logic m_taken(input logic [5:0] br, input logic [31:0] a, input logic [31:0] b);
    logic t;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t = 1'b0;
    if (br[0] && a == b)   t = 1'b1;
    if (br[1] && a != b)   t = 1'b1;
    if (br[2] && sa < sb)  t = 1'b1;
    if (br[3] && sa >= sb) t = 1'b1;
    if (br[4] && a < b)    t = 1'b1;
    if (br[5] && a >= b)   t = 1'b1;
    return t;
  endfunction

  logic        e_valid = 1'b0, e_pcn = 1'b0;
  logic [31:0] e_res = '0, e_tgt = '0;
  logic [3:0]  e_flags = '0;

  // Model state advances on the same edge as the DUT.
  always @(posedge clk) begin
    if (!rst) begin
      e_valid <= 1'b0; e_res <= '0; e_flags <= '0; e_tgt <= '0; e_pcn <= 1'b0;
    end else if (in_valid) begin
      e_valid <= 1'b1;
      e_res   <= m_alu(ALUControl, srcA, srcB);
      e_flags <= m_flags(srcA, srcB);
      e_tgt   <= targetBase + targetOffset;
      e_pcn   <= jump | m_taken(branch, srcA, srcB);
    end else begin
      e_valid <= 1'b0;
      e_pcn   <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m.out_valid", {31'b0, out_valid}, {31'b0, e_valid});
      check("m.ALUResult", ALUResult, e_res);
      check("m.flags",     {28'b0, flags}, {28'b0, e_flags});
      check("m.PCTarget",  PCTarget, e_tgt);
      check("m.PCNextSrc", {31'b0, PCNextSrc}, {31'b0, e_pcn});
    end
  end

  // Apply one input vector; returns at the next negedge with its result visible.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [5:0] br, input logic j,
                      input logic [31:0] tbase, input logic [31:0] toff);
    in_valid = v; ALUControl = op; srcA = a; srcB = b; branch = br; jump = j;
    targetBase = tbase; targetOffset = toff;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    step(1'b1, 4'd0, 32'h1234, 32'h5678, 6'h3F, 1'b1, 32'h100, 32'h10);
    chk_en = 1'b1;
    step(1'b1, 4'd0, 32'h1234, 32'h5678, 6'h3F, 1'b1, 32'h100, 32'h10);
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.ALUResult", ALUResult, 32'd0);
    check("rst.flags",     {28'b0, flags}, 32'd0);
    check("rst.PCTarget",  PCTarget, 32'd0);
    check("rst.PCNextSrc", {31'b0, PCNextSrc}, 32'd0);

    rst = 1'b1;
    step(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 6'd0, 1'b0, 32'd0, 32'd0);
    check("add_wrap.valid", {31'b0, out_valid}, 32'd1);
    check("add_wrap.res",   ALUResult, 32'd0);
    check("add_wrap.flags", {28'b0, flags}, 32'h6);

    step(1'b1, 4'd1, 32'd5, 32'd5, 6'd0, 1'b0, 32'd0, 32'd0);
    check("sub_eq.res",   ALUResult, 32'd0);
    check("sub_eq.flags", {28'b0, flags}, 32'h5);

    step(1'b1, 4'd7, 32'h8000_0000, 32'h24, 6'd0, 1'b0, 32'd0, 32'd0);
    check("sra", ALUResult, 32'hF800_0000);
    step(1'b1, 4'd6, 32'h8000_0000, 32'h24, 6'd0, 1'b0, 32'd0, 32'd0);
    check("srl", ALUResult, 32'h0800_0000);
    step(1'b1, 4'd8, 32'hFFFF_FFFF, 32'd1, 6'd0, 1'b0, 32'd0, 32'd0);
    check("slt", ALUResult, 32'd1);
    step(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 6'd0, 1'b0, 32'd0, 32'd0);
    check("sltu", ALUResult, 32'd0);

    step(1'b1, 4'd1, 32'h8000_0000, 32'd1, 6'b000100, 1'b0, 32'd0, 32'd0);
    check("ovf.res",   ALUResult, 32'h7FFF_FFFF);
    check("ovf.flags", {28'b0, flags}, 32'hC);
    check("ovf.blt",   {31'b0, PCNextSrc}, 32'd1);
    step(1'b1, 4'd1, 32'h8000_0000, 32'd1, 6'b010000, 1'b0, 32'd0, 32'd0);
    check("ovf.bltu",  {31'b0, PCNextSrc}, 32'd0);

    step(1'b1, 4'd1, 32'd3, 32'd3, 6'b000010, 1'b0, 32'd0, 32'd0);
    check("bne_eq", {31'b0, PCNextSrc}, 32'd0);
    step(1'b1, 4'd0, 32'd0, 32'd0, 6'd0, 1'b1, 32'h100, 32'hFFFF_FFF8);
    check("jal.pcn", {31'b0, PCNextSrc}, 32'd1);
    check("jal.tgt", PCTarget, 32'h0000_00F8);

    step(1'b1, 4'd0, 32'd2, 32'd3, 6'b000001, 1'b0, 32'h40, 32'h4);
    check("hold.first", ALUResult, 32'd5);
    step(1'b0, 4'd1, 32'd9, 32'd1, 6'b000010, 1'b1, 32'h999, 32'h1);
    check("hold.res",   ALUResult, 32'd5);
    check("hold.valid", {31'b0, out_valid}, 32'd0);
    check("hold.pcn",   {31'b0, PCNextSrc}, 32'd0);
    check("hold.tgt",   PCTarget, 32'h44);

    // Randomized traffic, occasional mid-stream resets.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      logic [5:0]  br;
      a  = pick();
      b  = ($urandom_range(0, 5) == 0) ? a : pick();
      br = ($urandom_range(0, 2) == 0) ? 6'd0 : (6'd1 << $urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) br = 6'($urandom);
      rst = ($urandom_range(0, 40) != 0);
      step($urandom_range(0, 4) != 0, 4'($urandom), a, b, br,
           $urandom_range(0, 5) == 0, $urandom, $urandom);
      if (!rst) check("rnd.rst_drop", {31'b0, out_valid}, 32'd0);
    end

    rst = 1'b1;
    step(1'b0, 4'd0, 32'd0, 32'd0, 6'd0, 1'b0, 32'd0, 32'd0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
